branch_update_queue: RTL and testbench

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

---
 rtl/branch_update_queue.sv | 115 +++++++++++
 tb/tb_branch_update_queue.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// Commit-to-predictor branch update FIFO (circular buffer, drop counter).
// Optional zero-latency bypass on an empty queue: define BRQ_BYPASS_EN.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef GSH_BHR_LEN
`define GSH_BHR_LEN 10
`endif

module branch_update_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    combranch,
  input  logic [`ADDR_LEN-1:0]    pc_combranch,
  input  logic [`GSH_BHR_LEN-1:0] bhr_combranch,
  input  logic                    brcond_combranch,
  input  logic [`ADDR_LEN-1:0]    jmpaddr_combranch,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [`ADDR_LEN-1:0]    upd_pc,
  output logic [`GSH_BHR_LEN-1:0] upd_bhr,
  output logic                    upd_taken,
  output logic [`ADDR_LEN-1:0]    upd_target,
  output logic                    brq_afull,
  output logic [PTR_W:0]          brq_count,
  output logic [15:0]             drop_cnt
);

  localparam logic [PTR_W:0] LP_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_AFULL = (PTR_W+1)'(DEPTH - 1);

  logic [`ADDR_LEN-1:0]    r_pc     [DEPTH];
  logic [`GSH_BHR_LEN-1:0] r_bhr    [DEPTH];
  logic                    r_taken  [DEPTH];
  logic [`ADDR_LEN-1:0]    r_target [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [15:0]      r_drop;

  logic w_empty;
  logic w_full;
  logic w_byp;
  logic w_deq;
  logic w_enq;
  logic w_drop;

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == LP_FULL);
`ifdef BRQ_BYPASS_EN
    w_byp   = !reset && combranch && w_empty && upd_ready;
`else
    w_byp   = 1'b0;
`endif
    w_deq   = !w_empty && upd_ready;
    w_enq   = combranch && !w_byp && (!w_full || w_deq);
    w_drop  = combranch && w_full && !w_deq;
  end

  // A bypassed branch is consumed directly and never touches storage.
  always_comb begin
`ifdef BRQ_BYPASS_EN
    upd_valid  = !w_empty || w_byp;
    upd_pc     = w_byp ? pc_combranch      : r_pc[r_head];
    upd_bhr    = w_byp ? bhr_combranch     : r_bhr[r_head];
    upd_taken  = w_byp ? brcond_combranch  : r_taken[r_head];
    upd_target = w_byp ? jmpaddr_combranch : r_target[r_head];
`else
    upd_valid  = !w_empty;
    upd_pc     = r_pc[r_head];
    upd_bhr    = r_bhr[r_head];
    upd_taken  = r_taken[r_head];
    upd_target = r_target[r_head];
`endif
    brq_afull  = (r_count >= LP_AFULL);
    brq_count  = r_count;
    drop_cnt   = r_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_enq)
        r_tail <= r_tail + 1'b1;
      if (w_deq)
        r_head <= r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      r_pc[r_tail]     <= pc_combranch;
      r_bhr[r_tail]    <= bhr_combranch;
      r_taken[r_tail]  <= brcond_combranch;
      r_target[r_tail] <= jmpaddr_combranch;
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_branch_update_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        combranch;
  logic [31:0] pc_combranch;
  logic [9:0]  bhr_combranch;
  logic        brcond_combranch;
  logic [31:0] jmpaddr_combranch;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [9:0]  upd_bhr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        brq_afull;
  logic [2:0]  brq_count;
  logic [15:0] drop_cnt;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] pc;
    logic [9:0]  bhr;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mdrop;

  always #5 clk = ~clk;

  branch_update_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .reset(reset),
    .combranch(combranch),
    .pc_combranch(pc_combranch),
    .bhr_combranch(bhr_combranch),
    .brcond_combranch(brcond_combranch),
    .jmpaddr_combranch(jmpaddr_combranch),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_pc(upd_pc),
    .upd_bhr(upd_bhr),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .brq_afull(brq_afull),
    .brq_count(brq_count),
    .drop_cnt(drop_cnt)
  );

  // Reference model: FIFO of committed branches plus a saturating drop tally.
  always @(posedge clk) begin
    bit byp;
    bit deq;
    bit was_full;
    if (reset) begin
      mq.delete();
      mdrop = 16'd0;
    end else begin
      byp = 1'b0;
`ifdef BRQ_BYPASS_EN
      byp = combranch && (mq.size() == 0) && upd_ready;
`endif
      if (!byp) begin
        deq = (mq.size() != 0) && upd_ready;
        was_full = (mq.size() == DEPTH);
        if (deq)
          void'(mq.pop_front());
        if (combranch) begin
          if (!was_full || deq)
            mq.push_back({pc_combranch, bhr_combranch,
                          brcond_combranch, jmpaddr_combranch});
          else if (mdrop != 16'hFFFF)
            mdrop = mdrop + 16'd1;
        end
      end
    end
  end

  task automatic cyc(input logic c, input logic [31:0] pc,
                     input logic tk, input logic [31:0] tg,
                     input logic rdy, input logic rst);
    @(negedge clk);
    combranch         = c;
    pc_combranch      = pc;
    bhr_combranch     = pc[11:2] ^ 10'h2A5;
    brcond_combranch  = tk;
    jmpaddr_combranch = tg;
    upd_ready         = rdy;
    reset             = rst;
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 32'h44, 1'b1, 32'h88, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (upd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", upd_valid);
    end
    checks++;
    if (brq_count !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", brq_count);
    end
    checks++;
    if (brq_afull !== 1'b0) begin
      errors++; $display("FAIL reset_afull got %b want 0", brq_afull);
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_single();
    cyc(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    checks++;
`ifdef BRQ_BYPASS_EN
    if (upd_valid !== 1'b1 || upd_pc !== 32'h100) begin
      errors++;
      $display("FAIL single_bypass got v=%b pc=%h want v=1 pc=100",
               upd_valid, upd_pc);
    end
`else
    if (upd_valid !== 1'b0) begin
      errors++; $display("FAIL single_nolat got %b want 0", upd_valid);
    end
`endif
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef BRQ_BYPASS_EN
    checks++;
    if (upd_valid !== 1'b0) begin
      errors++; $display("FAIL single_after got %b want 0", upd_valid);
    end
`else
    checks++;
    if (upd_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got %b want 1", upd_valid);
    end
    checks++;
    if (upd_pc !== 32'h100) begin
      errors++; $display("FAIL single_pc got %h want 100", upd_pc);
    end
    checks++;
    if (upd_target !== 32'h200 || upd_taken !== 1'b1) begin
      errors++;
      $display("FAIL single_tgt got %h/%b want 200/1", upd_target, upd_taken);
    end
`endif
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (upd_valid !== 1'b0) begin
      errors++; $display("FAIL single_empty got %b want 0", upd_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h10 * (i + 1), 1'b0, 32'h1000 + i, 1'b0, 1'b0);
      if (i > 0) begin
        checks++;
        if (brq_count !== 3'(i)) begin
          errors++; $display("FAIL fill_count got %0d want %0d", brq_count, i);
        end
        checks++;
        if (upd_pc !== 32'h10) begin
          errors++; $display("FAIL fill_head got %h want 10", upd_pc);
        end
        checks++;
        if (brq_afull !== (i >= 3)) begin
          errors++;
          $display("FAIL fill_afull got %b want %b", brq_afull, i >= 3);
        end
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (brq_count !== 3'd4 || brq_afull !== 1'b1 || upd_pc !== 32'h10) begin
      errors++;
      $display("FAIL fill_full got cnt=%0d af=%b pc=%h want 4/1/10",
               brq_count, brq_afull, upd_pc);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 32'h50, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt);
    end
    checks++;
    if (brq_count !== 3'd4) begin
      errors++; $display("FAIL ovf_count got %0d want 4", brq_count);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 32'h10 * (i + 1)) begin
        errors++;
        $display("FAIL ovf_drain%0d got v=%b pc=%h want pc=%h",
                 i, upd_valid, upd_pc, 32'h10 * (i + 1));
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (upd_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_empty got %b want 0", upd_valid);
    end
  endtask

  task automatic test_full_traffic();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h60 + 32'h10 * i, 1'b1, 32'h2000 + i, 1'b0, 1'b0);
    cyc(1'b1, 32'hA0, 1'b0, 32'h3000, 1'b1, 1'b0);
    checks++;
    if (brq_count !== 3'd4 || upd_pc !== 32'h60) begin
      errors++;
      $display("FAIL fullt_pre got cnt=%0d pc=%h want 4/60", brq_count, upd_pc);
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (brq_count !== 3'd4 || drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL fullt_cnt got cnt=%0d drop=%0d want 4/1",
               brq_count, drop_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 32'h70 + 32'h10 * i) begin
        errors++;
        $display("FAIL fullt_order%0d got pc=%h want %h",
                 i, upd_pc, 32'h70 + 32'h10 * i);
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    int sent;
    logic rdy;
    sent = 0;
    rdy = 1'b0;
    for (int n = 0; n < 200 && got.size() < 10; n++) begin
      @(negedge clk);
      rdy = ~rdy;
      combranch         = (sent < 10) && (mq.size() < DEPTH - 1);
      pc_combranch      = 32'h300 + 32'(sent) * 4;
      bhr_combranch     = 10'(sent);
      brcond_combranch  = 1'b1;
      jmpaddr_combranch = 32'h400;
      upd_ready         = rdy;
      reset             = 1'b0;
      #1;
      if (combranch)
        sent++;
      if (upd_valid && upd_ready)
        got.push_back(upd_pc);
    end
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL wrap_count got %0d want 10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'h300 + 32'(i) * 4) begin
        errors++;
        $display("FAIL wrap_order%0d got %h want %h",
                 i, got[i], 32'h300 + 32'(i) * 4);
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 16'd1 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got drop=%0d v=%b want 1/0", drop_cnt, upd_valid);
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h500 + i, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h5F0, 1'b1, 32'h0, 1'b0, 1'b1);
    checks++;
    if (brq_count !== 3'd3) begin
      errors++; $display("FAIL mrst_pre got %0d want 3", brq_count);
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (brq_count !== 3'd0 || upd_valid !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mrst_post got cnt=%0d v=%b drop=%0d want 0/0/0",
               brq_count, upd_valid, drop_cnt);
    end
  endtask

  task automatic test_random();
    bit   byp;
    bit   ev;
    ent_t eh;
    int   rp;
    for (int n = 0; n < 600; n++) begin
      rp = ((n / 60) % 2) ? 80 : 25;
      cyc($urandom_range(0, 99) < 60, $urandom, 1'($urandom),
          $urandom, $urandom_range(0, 99) < rp,
          $urandom_range(0, 99) == 0);
      byp = 1'b0;
`ifdef BRQ_BYPASS_EN
      byp = !reset && combranch && (mq.size() == 0) && upd_ready;
`endif
      ev = (mq.size() != 0) || byp;
      checks++;
      if (upd_valid !== ev) begin
        errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, upd_valid, ev);
      end
      checks++;
      if (brq_count !== 3'(mq.size()) || brq_afull !== (mq.size() >= DEPTH - 1)) begin
        errors++;
        $display("FAIL rnd_count n=%0d got %0d/%b want %0d", n,
                 brq_count, brq_afull, mq.size());
      end
      checks++;
      if (drop_cnt !== mdrop) begin
        errors++; $display("FAIL rnd_drop n=%0d got %0d want %0d", n, drop_cnt, mdrop);
      end
      if (ev) begin
        eh = byp ? ent_t'({pc_combranch, bhr_combranch,
                           brcond_combranch, jmpaddr_combranch}) : mq[0];
        checks++;
        if ({upd_pc, upd_bhr, upd_taken, upd_target} !== eh) begin
          errors++;
          $display("FAIL rnd_head n=%0d got %h/%h/%b/%h want %h/%h/%b/%h", n,
                   upd_pc, upd_bhr, upd_taken, upd_target,
                   eh.pc, eh.bhr, eh.taken, eh.tgt);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdrop = 16'd0;
    reset = 1'b1;
    combranch = 1'b0;
    pc_combranch = '0;
    bhr_combranch = '0;
    brcond_combranch = 1'b0;
    jmpaddr_combranch = '0;
    upd_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_overflow();
    test_full_traffic();
    test_wrap();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
